// File: rtl/width_packer.sv
// Narrow-to-wide packer: gathers NSIZE beats of DSIZE bits into one word with lane mask and count.
// Optional idle-timeout flush of partial words is enabled by defining WIDTH_PACKER_TIMEOUT_EN.
module width_packer #(
  parameter int DSIZE     = 8,
  parameter int NSIZE     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 16
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic [DSIZE-1:0]          wr_data,
  input  logic                      wr_vld,
  output logic                      wr_ready,
  input  logic                      wr_last,
  input  logic                      wr_align_last,
  output logic [DSIZE*NSIZE-1:0]    rd_data,
  output logic [NSIZE-1:0]          rd_keep,
  output logic [$clog2(NSIZE+1)-1:0] rd_cnt,
  output logic                      rd_vld,
  input  logic                      rd_ready,
  output logic                      rd_last
);

  localparam int WW = DSIZE * NSIZE;
  localparam int CW = $clog2(NSIZE + 1);
  localparam int PW = (NSIZE > 1) ? $clog2(NSIZE) : 1;
  localparam logic [PW-1:0] LAST_LANE = PW'(NSIZE - 1);

  logic [WW-1:0]    acc_q, acc_d;
  logic [NSIZE-1:0] keep_q, keep_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WW-1:0]    rd_data_q, rd_data_d;
  logic [NSIZE-1:0] rd_keep_q, rd_keep_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_last_q, rd_last_d;

  logic             close_s;
  logic             slot_free_s;
  logic             wr_ready_s;
  logic             accept_s;
  logic             flush_s;
  logic             load_s;
  logic [PW-1:0]    lane_s;
  logic [WW-1:0]    merged_acc_s;
  logic [NSIZE-1:0] merged_keep_s;

  // Handshake decode: only a closing beat needs a free output slot.
  always_comb begin
    close_s     = (ptr_q == LAST_LANE) | wr_last | wr_align_last;
    slot_free_s = ~rd_vld_q | rd_ready;
    wr_ready_s  = ~close_s | slot_free_s;
    accept_s    = wr_vld & wr_ready_s;
    lane_s      = MSB_FIRST ? (LAST_LANE - ptr_q) : ptr_q;
  end

  // Accumulator with the current beat merged into its lane.
  always_comb begin
    merged_acc_s  = acc_q;
    merged_keep_s = keep_q;
    for (int i = 0; i < NSIZE; i++) begin
      merged_acc_s[DSIZE*i +: DSIZE] = (accept_s && (lane_s == PW'(i))) ?
                                       wr_data : acc_q[DSIZE*i +: DSIZE];
      merged_keep_s[i] = keep_q[i] | (accept_s && (lane_s == PW'(i)));
    end
  end

`ifdef WIDTH_PACKER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;

  // Idle counter saturates at its limit so a stalled flush keeps waiting.
  always_comb begin
    flush_s = (ptr_q != {PW{1'b0}}) && (tcnt_q == TOUT_LAST) && slot_free_s && !accept_s;
    if (accept_s || flush_s) begin
      tcnt_d = {TW{1'b0}};
    end else if ((ptr_q != {PW{1'b0}}) && (tcnt_q != TOUT_LAST)) begin
      tcnt_d = tcnt_q + TW'(1);
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  // Idle counter register.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      tcnt_q <= {TW{1'b0}};
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  assign flush_s = 1'b0;
`endif

  // Next-state: fill lanes, hand a closed word to the output register.
  always_comb begin
    load_s    = (accept_s & close_s) | flush_s;
    acc_d     = acc_q;
    keep_d    = keep_q;
    ptr_d     = ptr_q;
    rd_data_d = rd_data_q;
    rd_keep_d = rd_keep_q;
    rd_cnt_d  = rd_cnt_q;
    rd_last_d = rd_last_q;
    rd_vld_d  = rd_vld_q & ~rd_ready;
    if (load_s) begin
      rd_data_d = merged_acc_s;
      rd_keep_d = merged_keep_s;
      rd_cnt_d  = accept_s ? (CW'(ptr_q) + CW'(1)) : CW'(ptr_q);
      rd_last_d = accept_s & wr_last;
      rd_vld_d  = 1'b1;
      acc_d     = {WW{1'b0}};
      keep_d    = {NSIZE{1'b0}};
      ptr_d     = {PW{1'b0}};
    end else if (accept_s) begin
      acc_d  = merged_acc_s;
      keep_d = merged_keep_s;
      ptr_d  = ptr_q + PW'(1);
    end else begin
      acc_d = acc_q;
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      acc_q     <= {WW{1'b0}};
      keep_q    <= {NSIZE{1'b0}};
      ptr_q     <= {PW{1'b0}};
      rd_data_q <= {WW{1'b0}};
      rd_keep_q <= {NSIZE{1'b0}};
      rd_cnt_q  <= {CW{1'b0}};
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      keep_q    <= keep_d;
      ptr_q     <= ptr_d;
      rd_data_q <= rd_data_d;
      rd_keep_q <= rd_keep_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
    end
  end

  assign wr_ready = wr_ready_s;
  assign rd_data  = rd_data_q;
  assign rd_keep  = rd_keep_q;
  assign rd_cnt   = rd_cnt_q;
  assign rd_vld   = rd_vld_q;
  assign rd_last  = rd_last_q;

endmodule
